// File: rtl/ifetch32_pkg.sv
// Shared definitions for the ifetch32 instruction fetch stage.
package ifetch32_pkg;

  // Default first fetch address after reset (word aligned).
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Instruction field positions as seen by the downstream decoder.
  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int CLASS_HI = 27;
  localparam int CLASS_LO = 25;
  localparam int LINK_BIT = 24;

  // The decoder sees the PC two words ahead of the instruction it decodes.
  localparam logic [31:0] BR_PC_OFFSET = 32'd8;

  // Fetch FSM encoding.
  localparam logic [1:0] ST_RST_WAIT = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // One prefetch queue entry: instruction word and its address.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;

  // Branch target from the decode PC; low bits forced to a word boundary.
  function automatic logic [31:0] branch_target(input logic [31:0] dpc,
                                                input logic [31:0] bv);
    logic [31:0] t;
    t = dpc + BR_PC_OFFSET + bv;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch32_ifq.sv
// Small synchronous prefetch FIFO; flush overrides push and pop.
module ifetch32_ifq
  import ifetch32_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  fetch_entry_t                     push_data,
  input  logic                             pop,
  input  logic                             flush,
  output fetch_entry_t                     head,
  output logic [$clog2(QDEPTH+1)-1:0]      count,
  output logic                             full,
  output logic                             empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  fetch_entry_t    mem_reg [QDEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == CW'(QDEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ifetch32.sv
// Instruction fetch stage: address generation, prefetch queue, decoder
// output register, branch redirect and link value generation.
module ifetch32
  import ifetch32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        istall,
  output logic [31:0] iout,
  output logic        ivalid,
  output logic [31:0] ipc,
  input  logic        ib,
  input  logic [31:0] bv,
  input  logic        bl,
  output logic        link_we,
  output logic [31:0] link_data
);

  localparam int QCW = $clog2(QDEPTH+1);

  logic [1:0]     state_reg;
  logic [31:0]    pc_reg;
  logic [31:0]    dpc_reg;
  logic           xfer;
  logic           q_push;
  logic           q_pop;
  logic           handoff;
  fetch_entry_t   q_in;
  fetch_entry_t   q_head;
  logic [QCW-1:0] q_count;
  logic           q_full;
  logic           q_empty;

  // Request depends only on registered state, never on istall.
  assign imem_req  = (state_reg == ST_FETCH) && (q_count < QCW'(QDEPTH));
  assign imem_addr = pc_reg;
  assign xfer      = imem_req & imem_ack;
  // A word acked in the branch cycle belongs to the wrong path: drop it.
  assign q_push    = xfer & ~ib & ~q_full;
  assign handoff   = ivalid & ~istall;
  assign q_pop     = ~ib & (~ivalid | handoff) & ~q_empty;
  assign q_in      = '{insn: imem_rdata, pc: pc_reg};

  ifetch32_ifq #(.QDEPTH(QDEPTH)) u_ifq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .flush     (ib),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Fetch FSM: one settle cycle after reset, one bubble cycle per redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RST_WAIT;
    end else if (ib) begin
      state_reg <= ST_REDIRECT;
    end else begin
      case (state_reg)
        ST_RST_WAIT: state_reg <= ST_FETCH;
        ST_FETCH:    state_reg <= ST_FETCH;
        ST_REDIRECT: state_reg <= ST_FETCH;
        default:     state_reg <= ST_RST_WAIT;
      endcase
    end
  end

  // Fetch PC: branch target wins, otherwise advance on each accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (ib) begin
      pc_reg <= branch_target(dpc_reg, bv);
    end else if (xfer) begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  // Decoder output register: squash on branch, refill from the queue head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iout   <= '0;
      ipc    <= '0;
      ivalid <= 1'b0;
    end else if (ib) begin
      ivalid <= 1'b0;
    end else if (q_pop) begin
      iout   <= q_head.insn;
      ipc    <= q_head.pc;
      ivalid <= 1'b1;
    end else if (handoff) begin
      ivalid <= 1'b0;
    end
  end

  // Decode PC follows each accepted instruction; a branch freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpc_reg <= '0;
    end else if (!ib && handoff) begin
      dpc_reg <= ipc;
    end
  end

  // Return address strobe for branch-with-link; data holds between links.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_we   <= 1'b0;
      link_data <= '0;
    end else begin
      link_we <= ib & bl;
      if (ib && bl) begin
        link_data <= dpc_reg + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_ifetch32.sv
// Scoreboard bench for ifetch32: stimulus queues expected PCs, a negedge
// monitor pops and checks each instruction the decoder accepts.
module tb_ifetch32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack;
  logic        istall;
  logic        ib;
  logic        bl;
  logic [31:0] bv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] iout;
  logic        ivalid;
  logic [31:0] ipc;
  logic        link_we;
  logic [31:0] link_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Memory model: word at address A holds A>>2.
  assign imem_rdata = imem_addr >> 2;

  always #5 clk = ~clk;

  ifetch32 #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .istall     (istall),
    .iout       (iout),
    .ivalid     (ivalid),
    .ipc        (ipc),
    .ib         (ib),
    .bv         (bv),
    .bl         (bl),
    .link_we    (link_we),
    .link_data  (link_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_range(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Wait (bounded) until the output register shows a given PC.
  task automatic wait_ipc(input logic [31:0] target, input string name);
    bit hit = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ivalid && ipc == target) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: timeout, last ipc %h required %h", name, ipc, target);
    end
  endtask

  // Wait (bounded) for the next valid instruction after a redirect.
  task automatic wait_valid(input string name);
    bit hit = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ivalid) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: ivalid never rose, got %b required 1", name, ivalid);
    end
  endtask

  // Random ack/stall traffic until all queued expectations are consumed.
  task automatic run_random(input string name);
    bit done = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      imem_ack = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0) begin istall = 1'b1; done = 1; break; end
      istall = ($urandom_range(0, 3) == 0);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: stream stalled, %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ivalid"},    32'(ivalid),   32'h0);
    chk({tag, "_iout"},      iout,          32'h0);
    chk({tag, "_ipc"},       ipc,           32'h0);
    chk({tag, "_req"},       32'(imem_req), 32'h0);
    chk({tag, "_addr"},      imem_addr,     32'h0);
    chk({tag, "_link_we"},   32'(link_we),  32'h0);
    chk({tag, "_link_data"}, link_data,     32'h0);
  endtask

  // Monitor: a handoff happens at the next edge when ivalid & !istall & !ib.
  always @(negedge clk) begin
    if (rst_n && ivalid && !istall && !ib) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", ipc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("handoff ipc=%h iout=%h expected_pc=%h", ipc, iout, e);
        chk("sb_pc", ipc, e);
        chk("sb_insn", iout, e >> 2);
      end
    end
  end

  initial begin
    imem_ack = 1'b1; istall = 1'b0; ib = 1'b0; bl = 1'b0; bv = '0;

    // Held in reset.
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("reset");

    // Release: first edge leaves RST_WAIT, second acks word 0, third shows it.
    push_range(32'h0, 9);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_ivalid", 32'(ivalid), 32'h0);
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    chk("fetch_ivalid", 32'(ivalid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stream_valid", 32'(ivalid), 32'h1);
      chk("stream_ipc", ipc, 32'(4 * k));
      chk("stream_iout", iout, 32'(k));
    end

    // Stall five cycles at ipc 0x10.
    wait_ipc(32'h10, "wait_stall_point");
    istall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      chk("stall_ipc_hold", ipc, 32'h10);
      chk("stall_iout_hold", iout, 32'h4);
      chk("stall_req_full", 32'(imem_req), 32'h0);
    end
    istall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("resume_ipc", ipc, 32'h14 + 32'(4 * k));
    end

    // Branch with link at dpc 0x20: target 0x38, link 0x24.
    wait_ipc(32'h24, "wait_br1");
    ib = 1'b1; bv = 32'h10; bl = 1'b1;
    push_range(32'h38, 51);
    @(posedge clk); #1;
    chk("br1_link_we", 32'(link_we), 32'h1);
    chk("br1_link_data", link_data, 32'h24);
    chk("br1_squash", 32'(ivalid), 32'h0);
    chk("br1_redirect_req", 32'(imem_req), 32'h0);
    ib = 1'b0; bl = 1'b0; bv = '0;
    @(posedge clk); #1;
    chk("br1_link_we_pulse", 32'(link_we), 32'h0);
    chk("br1_req", 32'(imem_req), 32'h1);
    chk("br1_addr", imem_addr, 32'h38);
    wait_valid("br1_valid");
    chk("br1_target", ipc, 32'h38);

    // Backward branch at dpc 0x100 with offset -8: target 0x100, no link.
    wait_ipc(32'h104, "wait_br2");
    ib = 1'b1; bv = 32'hFFFF_FFF8; bl = 1'b0;
    push_range(32'h100, 4);
    @(posedge clk); #1;
    chk("br2_link_we", 32'(link_we), 32'h0);
    chk("br2_link_hold", link_data, 32'h24);
    chk("br2_squash", 32'(ivalid), 32'h0);
    ib = 1'b0; bv = '0;
    wait_valid("br2_valid");
    chk("br2_target", ipc, 32'h100);

    // Branch while stalled with a full queue: dpc 0x10C, target 0x154.
    wait_ipc(32'h110, "wait_br3");
    istall = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("br3_full_req", 32'(imem_req), 32'h0);
    chk("br3_hold_ipc", ipc, 32'h110);
    ib = 1'b1; bv = 32'h40;
    exp_q.push_back(32'h154);
    @(posedge clk); #1;
    chk("br3_squash", 32'(ivalid), 32'h0);
    chk("br3_redirect_req", 32'(imem_req), 32'h0);
    ib = 1'b0; istall = 1'b0; bv = '0;
    @(posedge clk); #1;
    chk("br3_req", 32'(imem_req), 32'h1);
    chk("br3_addr", imem_addr, 32'h154);
    wait_valid("br3_valid");
    chk("br3_target", ipc, 32'h154);

    // Misaligned-sum branch to 0xFFFFFFF8 at dpc 0x154, then PC wraps to 0.
    wait_ipc(32'h158, "wait_br4");
    ib = 1'b1; bv = 32'hFFFF_FE9F; bl = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    push_range(32'h0, 3);
    @(posedge clk); #1;
    chk("br4_link_we", 32'(link_we), 32'h1);
    chk("br4_link_data", link_data, 32'h158);
    ib = 1'b0; bl = 1'b0; bv = '0;
    wait_valid("br4_valid");
    chk("br4_target", ipc, 32'hFFFF_FFF8);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    istall = 1'b1;
    chk("wrap_drained", 32'(exp_q.size()), 32'h0);

    // Reset asserted mid-stall with random memory acks.
    repeat (4) begin
      @(posedge clk); #1;
      imem_ack = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("async_reset1");
    repeat (2) @(negedge clk);
    push_range(32'h0, 16);
    rst_n = 1'b1;
    istall = 1'b0;
    run_random("random_run1");

    repeat (3) begin
      @(posedge clk); #1;
      imem_ack = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("async_reset2");
    repeat (2) @(negedge clk);
    push_range(32'h0, 20);
    rst_n = 1'b1;
    istall = 1'b0;
    run_random("random_run2");

    repeat (3) @(posedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
